// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART receiver and transmitter.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
    localparam int UART_OVERSAMPLE = 16;
    localparam logic [4:0] UART_MIN_BITS = 5'd5;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;
    // Requested word length forced into [UART_MIN_BITS, maxw].
    function automatic logic [4:0] clamp_bits(input logic [4:0] b, input int unsigned maxw);
        return (b < UART_MIN_BITS) ? UART_MIN_BITS : (32'(b) > maxw) ? 5'(maxw) : b;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with sticky frame/overrun flags and ack handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clken,
    input  logic                  rx,
    input  logic [4:0]            bits_per_word,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    uart_state_e           state_q;
    logic [TW-1:0]         tick_q, tick_d;
    logic [4:0]            bit_cnt_q, nbits_q, nbits_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q;
    logic                  valid_q, frame_err_q, overrun_q, armed_q, rx_prev_q, rx_s;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_q;
    assign parity_err = parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign nbits_d = clamp_bits(bits_per_word, DATA_WIDTH);
    assign shift_d = shift_q | (DATA_WIDTH'(rx_s) << bit_cnt_q);
    assign tick_d  = (tick_q == LAST) ? '0 : tick_q + 1'b1;

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_cnt_q   <= '0;
            nbits_q     <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b0;
            rx_prev_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q <= rx_s;
            if (rx_ack) begin
                valid_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            // Later assignments below deliberately override the ack clears.
            if (!en) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (clken && rx_s) armed_q <= 1'b1;
                        if (armed_q && rx_prev_q && !rx_s) begin
                            state_q   <= ST_START;
                            armed_q   <= 1'b0;
                            tick_q    <= '0;
                            bit_cnt_q <= '0;
                            nbits_q   <= nbits_d;
                            shift_q   <= '0;
                        end
                    end
                    ST_START: if (clken) begin
                        tick_q <= (tick_q == HALF) ? '0 : tick_q + 1'b1;
                        if (tick_q == HALF) state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: if (clken) begin
                        tick_q <= tick_d;
                        if (tick_q == LAST) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (bit_cnt_q == nbits_q - 1'b1) state_q <= ST_PARITY;
`else
                            if (bit_cnt_q == nbits_q - 1'b1) state_q <= ST_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: if (clken) begin
                        tick_q <= tick_d;
                        if (tick_q == LAST) begin
                            state_q <= ST_STOP;
                            if (rx_s != ^shift_q) parity_err_q <= 1'b1;
                        end
                    end
`endif
                    ST_STOP: if (clken) begin
                        tick_q <= tick_d;
                        if (tick_q == LAST) begin
                            state_q <= ST_IDLE;
                            if (rx_s) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                if (valid_q && !rx_ack) overrun_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of data_out and maximum word length.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: clken ticks per bit period.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: receiver enable.
REQ-006 SHALL have port clken, input, 1: one-clk oversample tick from the baud generator.
REQ-007 SHALL have port rx, input, 1: serial line, asynchronous, idle high.
REQ-008 SHALL have port bits_per_word, input, 5: data bits per frame.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: last received word.
REQ-010 SHALL have port rx_valid, output, 1: data_out holds an unacknowledged word.
REQ-011 SHALL have port rx_ack, input, 1: consumer has read data_out.
REQ-012 SHALL have port rx_busy, output, 1: frame in progress.
REQ-013 SHALL have port frame_err, output, 1: sticky; stop bit sampled low.
REQ-014 SHALL have port overrun, output, 1: sticky; word completed while rx_valid was high.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer before use; every later reference to rx means the synchronized value.
REQ-016 SHALL have FSM states IDLE, START, DATA, (PARITY), STOP; counters advance only on clken.
REQ-017 IDLE: SHALL go to START on a 1->0 transition of rx while en=1, and only if rx has been high at least one clken since the last frame or since reset.
REQ-018 START: SHALL sample at tick OVERSAMPLE/2-1 (tick 7); rx=1 means a false start and SHALL return to IDLE with no flags; rx=0 SHALL restart the tick counter and enter DATA.
REQ-019 DATA: SHALL sample mid-bit every OVERSAMPLE ticks, LSB first, for N bits; then enter PARITY or STOP.
REQ-020 N SHALL be bits_per_word latched on START entry; values 0..4 SHALL act as 5, values >DATA_WIDTH SHALL act as DATA_WIDTH.
REQ-021 Word bits above N-1 SHALL be zero.
REQ-022 STOP: SHALL sample mid-bit. On rx=1: load data_out and set rx_valid in the same clk, then go to IDLE. On rx=0: set frame_err, leave data_out and rx_valid unchanged, then go to IDLE.
REQ-023 SHALL give a latency of 1 clk from the clken that samples the stop bit to rx_valid=1.
REQ-024 rx_ack=1 SHALL clear rx_valid, frame_err and overrun on the next clk.
REQ-025 If rx_ack and a word completion occur in the same cycle, the new word SHALL win: rx_valid=1, overrun=0.
REQ-026 On word completion with rx_valid=1 and no rx_ack: overrun SHALL be set and data_out SHALL be overwritten with the newest word.
REQ-027 rx_busy SHALL be 1 in every state except IDLE.
REQ-028 en=0 in any state SHALL return the FSM to IDLE on the next clk, discarding the partial word; data_out, rx_valid and flags SHALL be held.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, data_out 0, rx_valid 0, rx_busy 0, frame_err 0, overrun 0.
REQ-030 Reset mid-frame SHALL drop the partial word; no rx_valid SHALL follow deassertion.

Configuration
REQ-031 With UART_RX_PARITY_EN defined: the PARITY state SHALL follow DATA, sample one even-parity bit over the N data bits, and drive an extra sticky output parity_err (1-bit, reset 0, cleared by rx_ack). On mismatch, the word SHALL still be delivered.
REQ-032 Without UART_RX_PARITY_EN: there SHALL be no PARITY state and no parity_err port; DATA SHALL go directly to STOP.

Structure
REQ-033 State encoding, the OVERSAMPLE default and the minimum word length (5) SHALL live in shared package uart_pkg, used by uart_rx and uart_tx alike.
REQ-034 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); the FSM and datapath SHALL be flat within uart_rx.

Verification
REQ-035 8-bit frame 0xA5, clken every 4 clk -> data_out=0x00A5, rx_valid=1, frame_err=0 after stop mid-sample.
REQ-036 rx low for 5 ticks only, then high -> no state beyond START, rx_valid=0, rx_busy returns to 0.
REQ-037 Two 8-bit frames 0x12 then 0x34, no rx_ack -> data_out=0x0034, overrun=1; rx_ack pulse -> rx_valid=0, overrun=0.
REQ-038 Frame with stop bit=0 (break held 20 bits) -> frame_err=1, rx_valid unchanged, no new START until rx has been high one tick.
REQ-039 bits_per_word=16, word 0xBEEF -> data_out=0xBEEF; bits_per_word=3, 5 data bits 0x1F -> data_out=0x001F.
REQ-040 rst asserted at data bit 4 of frame 0x55 -> all outputs 0 immediately; after release, no rx_valid for that frame.
